// File: rtl/dmem_sram_bridge_if.sv
// SRAM-like data bus between the M-stage bridge (master) and the data memory (slave).
// One request is in flight at a time: req/addr_ok handshake first, then data_ok.
interface dmem_sram_bridge_if;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/dmem_sram_bridge.sv
// M-stage load/store to SRAM-like bus bridge; stalls the pipeline for at least 2 cycles per
// access (req+addr_ok, then data_ok) and holds load data in DONE until the M stage advances.
module dmem_sram_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic [3:0]  mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_flush,
   input  logic        m_advance,
   output logic [31:0] mem_rdata,
   output logic        mem_stall,
   dmem_sram_bridge_if.master bus
);

   typedef enum logic [2:0] {IDLE, WAIT_ADDR, WAIT_DATA, DONE, DRAIN} stateT;

   stateT       state;
   logic        killed;
   logic        reqWr;
   logic [1:0]  reqSize;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;

   logic        decWr;
   logic [1:0]  decSize;
   logic [31:0] decAddr;
   logic        issue;

   // Loads always fetch the whole word; byte/half extraction happens in W.
   always_comb begin
      decSize = 2'd2;
      decAddr = {mem_addr[31:2], 2'b00};
      case (mem_wen)
         4'b0001: decSize = 2'd0;
         4'b0010: begin decSize = 2'd0; decAddr[1:0] = 2'b01; end
         4'b0100: begin decSize = 2'd0; decAddr[1:0] = 2'b10; end
         4'b1000: begin decSize = 2'd0; decAddr[1:0] = 2'b11; end
         4'b0011: decSize = 2'd1;
         4'b1100: begin decSize = 2'd1; decAddr[1:0] = 2'b10; end
         default: ;
      endcase
   end

   assign decWr = |mem_wen;
   assign issue = (state == IDLE) & mem_en & ~mem_flush;

   // Fields come from the latch once issued, so a flush that bubbles M cannot
   // alter or withdraw a request still waiting for addr_ok.
   assign bus.data_req   = issue | (state == WAIT_ADDR);
   assign bus.data_wr    = (state == IDLE) ? decWr     : reqWr;
   assign bus.data_size  = (state == IDLE) ? decSize   : reqSize;
   assign bus.data_addr  = (state == IDLE) ? decAddr   : reqAddr;
   assign bus.data_wdata = (state == IDLE) ? mem_wdata : reqWdata;

   assign mem_stall = issue | (state == WAIT_ADDR) | (state == WAIT_DATA) | (state == DRAIN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         killed    <= 1'b0;
         mem_rdata <= 32'd0;
         reqWr     <= 1'b0;
         reqSize   <= 2'd0;
         reqAddr   <= 32'd0;
         reqWdata  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               killed <= 1'b0;
               if (issue) begin
                  reqWr    <= decWr;
                  reqSize  <= decSize;
                  reqAddr  <= decAddr;
                  reqWdata <= mem_wdata;
                  state    <= bus.data_addr_ok ? WAIT_DATA : WAIT_ADDR;
               end
            end
            WAIT_ADDR: begin
               if (mem_flush) killed <= 1'b1;
               if (bus.data_addr_ok) state <= (killed | mem_flush) ? DRAIN : WAIT_DATA;
            end
            WAIT_DATA: begin
               if (mem_flush) killed <= 1'b1;
               if (bus.data_data_ok) begin
                  if (killed | mem_flush) begin
                     state <= IDLE;
                  end else begin
                     if (!reqWr) mem_rdata <= bus.data_rdata;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               // Stay put (no re-issue) while another unit holds the pipeline.
               if (m_advance | mem_flush) state <= IDLE;
            end
            DRAIN: begin
               if (bus.data_data_ok) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
